// File: rtl/code_patch_loader.sv
// Bit-serial loader for the code-patch table: assembles index+data frames into 22-bit entries.
// Optional macro CODE_PATCH_PARITY_EN appends an odd-parity bit covering index and data.
module code_patch_loader #(
    parameter int ENTRY_W     = 22,
    parameter int NUM_ENTRIES = 3,
    parameter int IDX_W       = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_pat_gen_i,
    input  logic                           clr_i,
    input  logic                           si_frame_i,
    input  logic                           si_valid_i,
    input  logic                           si_data_i,
    output logic [NUM_ENTRIES*ENTRY_W-1:0] no_pg_o,
    output logic [NUM_ENTRIES-1:0]         entry_vld_o,
    output logic                           si_read_o,
    output logic                           busy_o,
    output logic                           err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDX,
        S_DATA,
        S_COMMIT,
        S_DRAIN
    } state_t;

`ifdef CODE_PATCH_PARITY_EN
    localparam int DATA_BITS = ENTRY_W + 1;
`else
    localparam int DATA_BITS = ENTRY_W;
`endif
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(IDX_W - 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [IDX_W:0]   NUM_E     = (IDX_W + 1)'(NUM_ENTRIES);

    state_t                         r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic [IDX_W-1:0]               r_idx;
    logic [ENTRY_W-1:0]             r_data;
    logic [NUM_ENTRIES*ENTRY_W-1:0] r_table;
    logic [NUM_ENTRIES-1:0]         r_vld;
    logic                           r_read;
    logic                           r_busy;
    logic                           r_err;
    logic                           w_data_bit;
    logic                           w_par_ok;
    logic                           w_commit_ok;

`ifdef CODE_PATCH_PARITY_EN
    logic r_par;
    // Last DATA-phase bit is the parity bit; XOR over all accepted bits must be odd.
    assign w_data_bit = (r_cnt != LAST_DATA);
    assign w_par_ok   = r_par;
`else
    assign w_data_bit = 1'b1;
    assign w_par_ok   = 1'b1;
`endif

    assign w_commit_ok = ({1'b0, r_idx} < NUM_E) && cfg_pat_gen_i && !clr_i && w_par_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_table <= '0;
            r_vld   <= '0;
            r_read  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
`ifdef CODE_PATCH_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_read <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (si_frame_i) begin
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDX;
                        if (si_valid_i) begin
                            r_idx <= IDX_W'({r_idx, si_data_i});
                            if (LAST_IDX == '0) r_state <= S_DATA;
                            else                r_cnt   <= CNT_W'(1);
                        end
`ifdef CODE_PATCH_PARITY_EN
                        r_par <= si_valid_i & si_data_i;
`endif
                    end
                end
                S_IDX: begin
                    if (!si_frame_i) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (si_valid_i) begin
                        r_idx <= IDX_W'({r_idx, si_data_i});
`ifdef CODE_PATCH_PARITY_EN
                        r_par <= r_par ^ si_data_i;
`endif
                        if (r_cnt == LAST_IDX) begin
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (!si_frame_i) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (si_valid_i) begin
                        if (w_data_bit) r_data <= ENTRY_W'({r_data, si_data_i});
`ifdef CODE_PATCH_PARITY_EN
                        r_par <= r_par ^ si_data_i;
`endif
                        if (r_cnt == LAST_DATA) begin
                            r_cnt   <= '0;
                            r_state <= S_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (w_commit_ok) begin
                        r_table[int'(r_idx)*ENTRY_W +: ENTRY_W] <= r_data;
                        r_vld[r_idx] <= 1'b1;
                        r_read       <= 1'b1;
                    end else if (!clr_i) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!si_frame_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (si_valid_i) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
            // Clear overrides any error or valid flag raised in the same cycle.
            if (clr_i) begin
                r_vld <= '0;
                r_err <= 1'b0;
            end
        end
    end

    assign no_pg_o     = r_table;
    assign entry_vld_o = r_vld;
    assign si_read_o   = r_read;
    assign busy_o      = r_busy;
    assign err_o       = r_err;

endmodule

// File: tb/tb_code_patch_loader.sv
// Directed self-checking bench for code_patch_loader; honours CODE_PATCH_PARITY_EN when defined.
module tb_code_patch_loader;

    logic        clk;
    logic        rst;
    logic        cfg;
    logic        clr;
    logic        frame;
    logic        valid;
    logic        sdata;
    logic [65:0] no_pg;
    logic [2:0]  vld;
    logic        rd;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    code_patch_loader #(
        .ENTRY_W    (22),
        .NUM_ENTRIES(3),
        .IDX_W      (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_pat_gen_i(cfg),
        .clr_i        (clr),
        .si_frame_i   (frame),
        .si_valid_i   (valid),
        .si_data_i    (sdata),
        .no_pg_o      (no_pg),
        .entry_vld_o  (vld),
        .si_read_o    (rd),
        .busy_o       (busy),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a full frame; returns #1 after the edge that samples its last bit.
    task automatic send_frame(input logic [1:0] idx, input logic [21:0] d, input logic bad_par);
        logic [23:0] vec;
        vec   = {idx, d};
        frame = 1'b1;
        for (int i = 23; i >= 0; i--) begin
            valid = 1'b1;
            sdata = vec[i];
            tick();
        end
`ifdef CODE_PATCH_PARITY_EN
        valid = 1'b1;
        sdata = (~^vec) ^ bad_par;
        tick();
`else
        if (bad_par) sdata = 1'b0;
`endif
        valid = 1'b0;
        sdata = 1'b0;
    endtask

    // Commit edge, then envelope drop and return to IDLE.
    task automatic finish_frame();
        tick();
        frame = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg = 1'b1; clr = 1'b0; frame = 1'b0; valid = 1'b0; sdata = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_no_pg", no_pg, 66'h0);
        check("rst_vld",   {63'h0, vld}, 66'h0);
        check("rst_read",  {65'h0, rd}, 66'h0);
        check("rst_busy",  {65'h0, busy}, 66'h0);
        check("rst_err",   {65'h0, err}, 66'h0);

        // Entry 1 commit and its latency
        send_frame(2'd1, 22'h2A5F3C, 1'b0);
        check("t1_read_early", {65'h0, rd}, 66'h0);
        check("t1_busy",       {65'h0, busy}, 66'h1);
        finish_frame();
        check("t1_entry1", {44'h0, no_pg[43:22]}, {44'h0, 22'h2A5F3C});
        check("t1_vld",    {63'h0, vld}, 66'h2);
        check("t1_read",   {65'h0, rd}, 66'h1);
        check("t1_err",    {65'h0, err}, 66'h0);
        tick();
        check("t1_read_off", {65'h0, rd}, 66'h0);
        check("t1_idle",     {65'h0, busy}, 66'h0);

        // Out-of-range index
        send_frame(2'd3, 22'h000001, 1'b0);
        finish_frame();
        check("t2_read",  {65'h0, rd}, 66'h0);
        check("t2_vld",   {63'h0, vld}, 66'h2);
        check("t2_table", no_pg, {22'h0, 22'h2A5F3C, 22'h0});
        check("t2_err",   {65'h0, err}, 66'h1);
        tick();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_err",   {65'h0, err}, 66'h0);
        check("clr_vld",   {63'h0, vld}, 66'h0);
        check("clr_table", no_pg, {22'h0, 22'h2A5F3C, 22'h0});

        // Abort after 10 valid bits
        frame = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1;
            sdata = 1'b1;
            tick();
        end
        frame = 1'b0;
        valid = 1'b0;
        tick();
        check("t3_busy",  {65'h0, busy}, 66'h0);
        check("t3_err",   {65'h0, err}, 66'h1);
        check("t3_table", no_pg, {22'h0, 22'h2A5F3C, 22'h0});
        send_frame(2'd0, 22'h155555, 1'b0);
        finish_frame();
        check("t3_read",   {65'h0, rd}, 66'h1);
        check("t3_table2", no_pg, {22'h0, 22'h2A5F3C, 22'h155555});
        check("t3_vld",    {63'h0, vld}, 66'h1);
        tick();

        // Commit blocked by cfg_pat_gen_i, then clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cfg = 1'b0;
        send_frame(2'd2, 22'h0ABCDE, 1'b0);
        finish_frame();
        check("t4_read",   {65'h0, rd}, 66'h0);
        check("t4_err",    {65'h0, err}, 66'h1);
        check("t4_entry2", {44'h0, no_pg[65:44]}, 66'h0);
        tick();
        cfg = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_vld", {63'h0, vld}, 66'h0);
        check("t4_clr_err", {65'h0, err}, 66'h0);

        // Back-to-back rewrite of entry 0
        send_frame(2'd0, 22'h3FFFFF, 1'b0);
        finish_frame();
        check("t5_read1", {65'h0, rd}, 66'h1);
        check("t5_ent0a", {44'h0, no_pg[21:0]}, {44'h0, 22'h3FFFFF});
        tick();
        send_frame(2'd0, 22'h000001, 1'b0);
        finish_frame();
        check("t5_read2", {65'h0, rd}, 66'h1);
        check("t5_ent0b", {44'h0, no_pg[21:0]}, 66'h1);
        check("t5_vld",   {63'h0, vld}, 66'h1);
        check("t5_err",   {65'h0, err}, 66'h0);
        tick();

        // Extra bits in DRAIN; clr wins over same-cycle error
        send_frame(2'd1, 22'h000000, 1'b0);
        tick();
        check("t6_commit", no_pg, {22'h0, 22'h0, 22'h1});
        check("t6_err0",   {65'h0, err}, 66'h0);
        valid = 1'b1;
        sdata = 1'b1;
        clr   = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_clr_win", {65'h0, err}, 66'h0);
        check("t6_clr_vld", {63'h0, vld}, 66'h0);
        tick();
        valid = 1'b0;
        check("t6_extra_err", {65'h0, err}, 66'h1);
        check("t6_busy",      {65'h0, busy}, 66'h1);
        frame = 1'b0;
        tick();
        check("t6_idle", {65'h0, busy}, 66'h0);

`ifdef CODE_PATCH_PARITY_EN
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send_frame(2'd2, 22'h000003, 1'b1);
        finish_frame();
        check("par_bad_read", {65'h0, rd}, 66'h0);
        check("par_bad_err",  {65'h0, err}, 66'h1);
        tick();
        send_frame(2'd2, 22'h000003, 1'b0);
        finish_frame();
        check("par_good_read", {65'h0, rd}, 66'h1);
        check("par_good_ent2", {44'h0, no_pg[65:44]}, 66'h3);
        tick();
`endif

        // Reset mid-frame
        frame = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            sdata = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        frame = 1'b0;
        valid = 1'b0;
        check("t7_busy",  {65'h0, busy}, 66'h0);
        check("t7_table", no_pg, 66'h0);
        check("t7_err",   {65'h0, err}, 66'h0);
        tick();
        check("t7_idle", {65'h0, busy}, 66'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_patch_loader.md
# code_patch_loader

Serial loader for the code-patch table. It assembles bit-serial patch frames into 22-bit entries and presents the populated table to `code_patch_core` as `no_pg_o`, with per-entry valid flags. On each commit it emits a one-cycle `si_read_o` strobe, which is the read-qualifier input of `code_patch_core`.

## Interface
Parameters:
- `ENTRY_W`, 22, width of one patch entry.
- `NUM_ENTRIES`, 3, number of table entries.
- `IDX_W`, 2, width of the entry index field in a frame.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cfg_pat_gen_i`  in  1  patch-generation enable; commits are allowed only while it is high.
- `clr_i`  in  1  synchronous clear of all valid flags and `err_o`.
- `si_frame_i`  in  1  frame envelope; high for the whole frame.
- `si_valid_i`  in  1  qualifies `si_data_i` for one bit.
- `si_data_i`  in  1  serial data, MSB first.
- `no_pg_o`  out  NUM_ENTRIES*ENTRY_W  table contents; entry k is at bits [k*ENTRY_W +: ENTRY_W].
- `entry_vld_o`  out  NUM_ENTRIES  per-entry valid flags.
- `si_read_o`  out  1  one-cycle pulse per successful commit.
- `busy_o`  out  1  high in any state other than IDLE.
- `err_o`  out  1  sticky error flag.

## Operation
- Frame format: IDX_W index bits, then ENTRY_W data bits, MSB first. Only cycles with `si_valid_i`=1 count as bits. Base frame length is 24 bits.
- FSM states are IDLE, IDX, DATA, COMMIT and DRAIN.
  - IDLE → IDX when `si_frame_i`=1. A bit valid in that same cycle is accepted as index bit 0.
  - IDX → DATA after IDX_W bits.
  - DATA → COMMIT on the last data bit.
  - COMMIT → DRAIN unconditionally.
  - DRAIN → IDLE when `si_frame_i`=0.
- In IDX or DATA, if `si_frame_i` falls before the frame is complete:
  - the frame is aborted, `err_o` is set, and the FSM goes to IDLE;
  - no table state changes.
- In COMMIT the entry is written and its valid flag is set only if all of the following hold:
  - the index is less than NUM_ENTRIES,
  - `cfg_pat_gen_i`=1,
  - `clr_i`=0.
  - Otherwise the frame is discarded and `err_o` is set. The exception is a discard caused only by `clr_i`: this sets no error.
- Index 3 is out of range: the frame is discarded and `err_o`=1.
- In DRAIN, `si_valid_i`=1 while `si_frame_i`=1 (extra bits) sets `err_o`. The extra bits are ignored.
- `clr_i` clears all `entry_vld_o` bits and `err_o` in any state. It does not alter the FSM state or `no_pg_o` data.
  - If a new error event occurs in the same cycle as `clr_i`, `clr_i` wins.
- Rewriting an already-valid entry overwrites it and still pulses `si_read_o`.
- `no_pg_o` data changes only on a successful commit.

## Timing
- Reset values: `no_pg_o`=0, `entry_vld_o`=0, `si_read_o`=0, `busy_o`=0, `err_o`=0, FSM=IDLE.
- Reset mid-frame discards the partial frame.
- Commit latency:
  - The rising edge that samples the last data bit moves the FSM to COMMIT.
  - The next edge updates the entry, sets its valid flag and raises `si_read_o`. All three are visible together in the same cycle.
  - `si_read_o` is high for exactly that one cycle.
- Back-to-back frames: a new frame is recognised only after the envelope has dropped and the FSM has returned to IDLE. The minimum gap is one low cycle of `si_frame_i`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `CODE_PATCH_PARITY_EN` defined:
  - The frame carries one extra odd-parity bit after the data bits, covering index and data. Frame length is 25.
  - A parity mismatch at COMMIT discards the frame and sets `err_o`.
- `CODE_PATCH_PARITY_EN` undefined:
  - There is no parity bit and the frame length is 24.
  - A 25th valid bit is treated as an extra bit in DRAIN, which sets `err_o`.

## Test plan
- After reset, send frame index=1, data=22'h2A5F3C with `cfg_pat_gen_i`=1. Required response: two edges after the last bit, `no_pg_o`[43:22]=22'h2A5F3C, `entry_vld_o`=3'b010 and a one-cycle `si_read_o`; `err_o`=0.
- Send frame index=3, data=22'h1. Required response: table unchanged, `entry_vld_o` unchanged, `si_read_o` stays 0, `err_o`=1.
- Drop `si_frame_i` after 10 valid bits. Required response: FSM back in IDLE, `busy_o`=0, `err_o`=1, table unchanged. A following full frame for index 0 still commits.
- Send a full frame for index 2 with `cfg_pat_gen_i`=0. Required response: no commit, `err_o`=1. Then assert `clr_i`. Required response: `entry_vld_o`=0 and `err_o`=0 on the next cycle.
- Send index 0 with data=22'h3FFFFF, then index 0 with data=22'h000001 back-to-back, with one idle cycle between envelopes. Required response: two `si_read_o` pulses and a final `no_pg_o`[21:0]=22'h000001.
- With `CODE_PATCH_PARITY_EN`, send index 2, data=22'h000003 with the parity bit deliberately wrong. Required response: discard and `err_o`=1. Resending with correct parity commits the entry.
